// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned MAX_NREQ = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Index of the set bit in a one-hot (or zero) vector; zero input yields 0.
  function automatic int unsigned idx_of(input logic [MAX_NREQ-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals of the arbiter, bundled as one interface.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned WIDTH_FIFO = 8
);

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            req_last;
  logic [NREQ*WIDTH_FIFO-1:0] req_data;
  logic [NREQ-1:0]            ack;
  logic [NREQ-1:0]            gnt;
  logic                       busy;
  logic                       fifo_full;
  logic                       fifo_wen;
  logic [WIDTH_FIFO-1:0]      fifo_wdata;

  // Environment side: requesters plus the FIFO full flag.
  modport master (
    output req, req_last, req_data, fifo_full,
    input  ack, gnt, busy, fifo_wen, fifo_wdata
  );

  // Arbiter side.
  modport slave (
    input  req, req_last, req_data, fifo_full,
    output ack, gnt, busy, fifo_wen, fifo_wdata
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arb_core.sv
// Combinational round-robin pick: first requester after ptr, found by
// rotating a doubled request vector, isolating the lowest bit and rotating back.
module rr_arb_core
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner_oh,
  output logic [PW-1:0]   winner_idx
);

  localparam int unsigned SW = PW + 1;

  logic [SW-1:0]   sh;
  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;

  always_comb begin
    sh         = SW'(ptr) + SW'(1);
    rot        = NREQ'({req, req} >> sh);
    pick       = rot & (~rot + NREQ'(1));
    winner_oh  = NREQ'(({pick, pick} << sh) >> NREQ);
    winner_idx = PW'(idx_of(MAX_NREQ'(winner_oh)));
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters;
// a grant lasts until the last beat, BURST_MAX beats or an idle timeout.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned WIDTH_FIFO = 8,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned IDLE_TO    = 8
) (
  input logic             clk,
  input logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(BURST_MAX) + 1;
  localparam int unsigned IW = $clog2(IDLE_TO) + 1;

  state_e                state_q, state_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]         idle_cnt_q, idle_cnt_d;

  logic [NREQ-1:0]       win_oh;
  logic [PW-1:0]         win_idx;
  logic                  req_g;
  logic                  last_g;
  logic                  accept;
  logic [WIDTH_FIFO-1:0] wdata;

  rr_arb_core #(.NREQ(NREQ)) u_rr (
    .req        (bus.req),
    .ptr        (ptr_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx)
  );

  // AND-OR mux on the one-hot grant; an empty grant selects nothing and yields zero data.
  always_comb begin
    req_g  = |(bus.req & gnt_q);
    last_g = |(bus.req_last & gnt_q);
    wdata  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) wdata = wdata | bus.req_data[i*WIDTH_FIFO +: WIDTH_FIFO];
    end
  end

  // Beats are blocked while full and while reset is held, so the FIFO can never overflow.
  assign accept         = (state_q == ST_BURST) & req_g & ~bus.fifo_full & ~rst;
  assign bus.ack        = gnt_q & {NREQ{accept}};
  assign bus.fifo_wen   = accept;
  assign bus.fifo_wdata = wdata;
  assign bus.gnt        = gnt_q;
  assign bus.busy       = (state_q == ST_BURST);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d    = ST_BURST;
          gnt_d      = win_oh;
          ptr_d      = win_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          idle_cnt_d = '0;
          if (last_g || (beat_cnt_q == BW'(BURST_MAX - 1))) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (!req_g) begin
          idle_cnt_d = idle_cnt_q + IW'(1);
          if (idle_cnt_q == IW'(IDLE_TO - 1)) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
        // req high while full: stall, counters held.
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ptr_q      <= PW'(NREQ - 1);
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed cycle checks plus a
// random per-requester ordered-stream scoreboard.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned BMAX = 4;
  localparam int unsigned ITO  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH_FIFO(W)) bus ();

  fifo_wr_arbiter #(
    .NREQ(NREQ), .WIDTH_FIFO(W), .BURST_MAX(BMAX), .IDLE_TO(ITO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] fixed_data(input int idx);
    return W'(8'h11 * (idx + 1));
  endfunction

  task automatic load_fixed_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*W +: W] = fixed_data(i);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    load_fixed_data();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One cycle with the current inputs: sample at negedge, then advance past posedge.
  task automatic cyc(input string tag, input int e_idx, input logic e_wen);
    logic [NREQ-1:0] e_gnt;
    logic [W-1:0]    e_wd;
    e_gnt = (e_idx < 0) ? '0 : NREQ'(1) << e_idx;
    e_wd  = (e_idx < 0) ? '0 : fixed_data(e_idx);
    @(negedge clk);
    check({tag, "_gnt"},  32'(bus.gnt), 32'(e_gnt));
    check({tag, "_busy"}, 32'(bus.busy), 32'(e_idx >= 0));
    check({tag, "_wen"},  32'(bus.fifo_wen), 32'(e_wen));
    check({tag, "_ack"},  32'(bus.ack), 32'(e_wen ? e_gnt : '0));
    check({tag, "_wd"},   32'(bus.fifo_wdata), 32'(e_wd));
    @(posedge clk); #1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};
  logic [NREQ-1:0] pend [2] = '{4'b0010, 4'b1010};
  int              nxt  [2] = '{1, 3};

  logic [W-1:0]    exp_q [NREQ][$];
  logic [5:0]      seq   [NREQ];
  logic [NREQ-1:0] last_ack, prev_gnt, s_gnt, s_ack;
  logic            prev_busy, s_busy, s_wen, s_full;
  logic [W-1:0]    s_wd, d, e;
  int              beats, n_wr, g;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: single requester, last on 3rd beat
    do_reset();
    cyc("t1_rst", -1, 1'b0);
    bus.req = 4'b0001;
    cyc("t1_c0", -1, 1'b0);
    cyc("t1_b1", 0, 1'b1);
    cyc("t1_b2", 0, 1'b1);
    bus.req_last = 4'b0001;
    cyc("t1_b3", 0, 1'b1);
    bus.req = '0; bus.req_last = '0;
    cyc("t1_end", -1, 1'b0);

    // Test 2: all requesting, strict rotation, BURST_MAX beats, one dead cycle
    do_reset();
    bus.req = 4'b1111;
    cyc("t2_c0", -1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < int'(BMAX); b++) cyc("t2_beat", order[k], 1'b1);
      cyc("t2_dead", -1, 1'b0);
    end
    bus.req = '0;

    // Test 3: full stall longer than IDLE_TO keeps the grant
    do_reset();
    bus.req = 4'b0001;
    cyc("t3_c0", -1, 1'b0);
    cyc("t3_b1", 0, 1'b1);
    cyc("t3_b2", 0, 1'b1);
    bus.fifo_full = 1'b1;
    repeat (10) cyc("t3_stall", 0, 1'b0);
    bus.fifo_full = 1'b0;
    cyc("t3_b3", 0, 1'b1);
    cyc("t3_b4", 0, 1'b1);
    bus.req = '0;
    cyc("t3_end", -1, 1'b0);

    // Test 4: idle timeout on req2, next winner searched from ptr=2
    for (int v = 0; v < 2; v++) begin
      do_reset();
      bus.req = 4'b0100;
      cyc("t4_c0", -1, 1'b0);
      cyc("t4_b1", 2, 1'b1);
      bus.req = pend[v];
      repeat (ITO) cyc("t4_idle", 2, 1'b0);
      cyc("t4_tout", -1, 1'b0);
      cyc("t4_next", nxt[v], 1'b1);
    end

    // Test 5: reset mid-burst drops grant and returns ptr to NREQ-1
    do_reset();
    bus.req = 4'b0010;
    cyc("t5_c0", -1, 1'b0);
    cyc("t5_b1", 1, 1'b1);
    rst = 1'b1;
    bus.req = 4'b0011;
    cyc("t5_inrst", 1, 1'b0);
    rst = 1'b0;
    cyc("t5_after", -1, 1'b0);
    cyc("t5_next", 0, 1'b1);

    // Test 6: random traffic against per-requester ordered scoreboard
    do_reset();
    for (int i = 0; i < NREQ; i++) seq[i] = '0;
    last_ack  = '0;
    prev_gnt  = '0;
    prev_busy = 1'b0;
    beats     = 0;
    n_wr      = 0;
    for (int c = 0; c < 2300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && last_ack[i]) begin
          bus.req[i]      = 1'b0;
          bus.req_last[i] = 1'b0;
        end
        if (!bus.req[i] && c < 2000 && $urandom_range(0, 2) != 0) begin
          d = {2'(i), seq[i]};
          seq[i] = seq[i] + 6'd1;
          bus.req_data[i*W +: W] = d;
          bus.req_last[i] = ($urandom_range(0, 3) == 0);
          bus.req[i] = 1'b1;
          exp_q[i].push_back(d);
        end
      end
      bus.fifo_full = (c < 2000) ? ($urandom_range(0, 3) == 0) : 1'b0;

      @(negedge clk);
      s_gnt  = bus.gnt;
      s_ack  = bus.ack;
      s_busy = bus.busy;
      s_wen  = bus.fifo_wen;
      s_wd   = bus.fifo_wdata;
      s_full = bus.fifo_full;

      check("sb_ack", 32'(s_ack), 32'(s_wen ? s_gnt : '0));
      check("sb_onehot", 32'($onehot0(s_gnt)), 32'd1);
      if (prev_busy && s_busy) check("sb_interleave", 32'(s_gnt), 32'(prev_gnt));
      if (s_busy && !prev_busy) beats = 0;
      if (s_wen) begin
        n_wr++;
        beats++;
        check("sb_wen_full", 32'(s_full), 32'd0);
        check("sb_burst_len", 32'(beats <= int'(BMAX)), 32'd1);
        g = 0;
        for (int i = 0; i < NREQ; i++) if (s_gnt[i]) g = i;
        check("sb_underflow", 32'(exp_q[g].size() != 0), 32'd1);
        if (exp_q[g].size() != 0) begin
          e = exp_q[g].pop_front();
          check("sb_data", 32'(s_wd), 32'(e));
        end
      end
      last_ack  = s_ack;
      prev_gnt  = s_gnt;
      prev_busy = s_busy;
      @(posedge clk); #1;
    end
    for (int i = 0; i < NREQ; i++) check("sb_drain", 32'(exp_q[i].size()), 32'd0);
    check("sb_traffic", 32'(n_wr > 500), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
